// File: rtl/spi_sram_slave.sv
// SPI mode-0 SRAM slave with READ/WRITE and mode-register commands.
// SPI pins are oversampled by clk; a backdoor port gives benches direct array access.
module spi_sram_slave #(
    parameter int MEM_BYTES  = 256,
    parameter int ADDR_BYTES = 2,
    parameter int PAGE_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cs_n,
    input  logic                         sck,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [1:0]                   mode_o,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
    input  logic [7:0]                   bd_wdata,
    output logic [7:0]                   bd_rdata,
    output logic                         bd_err
);
    localparam int AW  = $clog2(MEM_BYTES);
    localparam int NB  = ADDR_BYTES * 8;
    localparam int RXW = (AW > 8) ? AW - 1 : 7;
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_RDMR, ST_WRMR, ST_IGNORE
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cs_sync_reg, sck_sync_reg;
    logic [1:0]      mosi_sync_reg;
    logic [RXW-1:0]  rx_reg;
    logic [4:0]      bit_cnt_reg;
    logic [3:0]      tx_cnt_reg;
    logic [7:0]      tx_reg;
    logic [AW-1:0]   addr_reg;
    logic [1:0]      mode_reg;
    logic            op_wr_reg;
    logic [7:0]      mem [MEM_BYTES];
    logic [7:0]      mem_q;

    logic            cs_s, cs_fall, sck_rise, sck_fall, mosi_s;
    logic [RXW:0]    rx_full;
    logic [7:0]      rx_byte, tx_src;
    logic            bit_in, op_set, addr_set, addr_adv, mem_we_spi, mode_we;
    logic            tx_load, tx_shift, bd_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_wa, addr_inc, addr_adv_val;
    logic [7:0]      mem_wd;

    // cs chain resets to "selected" so a reset mid-transaction never sees a fresh cs_n fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_reg   <= 3'b000;
            sck_sync_reg  <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[1:0], cs_n};
            sck_sync_reg  <= {sck_sync_reg[1:0], sck};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
        end
    end

    assign cs_s     = cs_sync_reg[1];
    assign cs_fall  = !cs_sync_reg[1] && cs_sync_reg[2];
    assign sck_rise = sck_sync_reg[1] && !sck_sync_reg[2];
    assign sck_fall = !sck_sync_reg[1] && sck_sync_reg[2];
    assign mosi_s   = mosi_sync_reg[1];
    assign rx_full  = {rx_reg, mosi_s};
    assign rx_byte  = rx_full[7:0];
    assign tx_src   = (state_reg == ST_RDMR) ? {mode_reg, 6'b0} : mem_q;
    assign bd_ok    = bd_we && (state_reg == ST_IDLE);
    assign mode_o   = mode_reg;

    assign addr_inc     = addr_reg + AW'(1);
    assign addr_adv_val = (mode_reg == 2'b10) ? ((addr_reg & ~PAGE_MASK) | (addr_inc & PAGE_MASK))
                                              : addr_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (cs_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (cs_fall) state_next = ST_CMD;
                ST_CMD:   if (sck_rise && bit_cnt_reg == 5'd7) begin
                              case (rx_byte)
                                  8'h03, 8'h02: state_next = ST_ADDR;
                                  8'h05:        state_next = ST_RDMR;
                                  8'h01:        state_next = ST_WRMR;
                                  default:      state_next = ST_IGNORE;
                              endcase
                          end
                ST_ADDR:  if (sck_rise && bit_cnt_reg == 5'(NB - 1))
                              state_next = op_wr_reg ? ST_WRITE : ST_READ;
                ST_READ:  if (sck_fall && tx_cnt_reg == 4'd8 && mode_reg == 2'b00)
                              state_next = ST_IGNORE;
                ST_WRITE: if (sck_rise && bit_cnt_reg == 5'd7 && mode_reg == 2'b00)
                              state_next = ST_IGNORE;
                ST_WRMR:  if (sck_rise && bit_cnt_reg == 5'd7) state_next = ST_IGNORE;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_in     = 1'b0;
        op_set     = 1'b0;
        addr_set   = 1'b0;
        addr_adv   = 1'b0;
        mem_we_spi = 1'b0;
        mode_we    = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        if (!cs_s) begin
            case (state_reg)
                ST_CMD: begin
                    bit_in = sck_rise;
                    op_set = sck_rise && bit_cnt_reg == 5'd7;
                end
                ST_ADDR: begin
                    bit_in   = sck_rise;
                    addr_set = sck_rise && bit_cnt_reg == 5'(NB - 1);
                end
                ST_WRITE: begin
                    bit_in     = sck_rise;
                    mem_we_spi = sck_rise && bit_cnt_reg == 5'd7;
                    addr_adv   = mem_we_spi;
                end
                ST_WRMR: begin
                    bit_in  = sck_rise;
                    mode_we = sck_rise && bit_cnt_reg == 5'd7;
                end
                // mem_q already holds the next byte: the address advanced on the previous load.
                ST_READ: if (sck_fall) begin
                    if (tx_cnt_reg == 4'd0 || (tx_cnt_reg == 4'd8 && mode_reg != 2'b00)) begin
                        tx_load  = 1'b1;
                        addr_adv = 1'b1;
                    end else if (tx_cnt_reg != 4'd8) begin
                        tx_shift = 1'b1;
                    end
                end
                ST_RDMR: if (sck_fall) begin
                    if (tx_cnt_reg == 4'd0 || tx_cnt_reg == 4'd8) tx_load  = 1'b1;
                    else                                          tx_shift = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            bd_rdata    <= 8'h00;
            bd_err      <= 1'b0;
            mode_reg    <= 2'b01;
            rx_reg      <= '0;
            bit_cnt_reg <= 5'd0;
            tx_cnt_reg  <= 4'd0;
            tx_reg      <= 8'h00;
            addr_reg    <= '0;
            op_wr_reg   <= 1'b0;
        end else begin
            bd_err   <= bd_we && !bd_ok;
            bd_rdata <= bd_ok ? bd_wdata : mem[bd_addr];
            if (bit_in) rx_reg <= rx_full[RXW-1:0];
            if (op_set) op_wr_reg <= (rx_byte == 8'h02);
            if (mode_we) mode_reg <= rx_byte[7:6];
            if (addr_set)      addr_reg <= rx_full[AW-1:0];
            else if (addr_adv) addr_reg <= addr_adv_val;

            if (state_next != state_reg) begin
                bit_cnt_reg <= 5'd0;
                tx_cnt_reg  <= 4'd0;
            end else if (bit_in) begin
                bit_cnt_reg <= (state_reg == ST_WRITE && bit_cnt_reg == 5'd7) ? 5'd0
                                                                              : bit_cnt_reg + 5'd1;
            end

            if (state_next != ST_READ && state_next != ST_RDMR) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else if (tx_load) begin
                miso       <= tx_src[7];
                miso_oe    <= 1'b1;
                tx_reg     <= {tx_src[6:0], 1'b0};
                tx_cnt_reg <= 4'd1;
            end else if (tx_shift) begin
                miso       <= tx_reg[7];
                tx_reg     <= {tx_reg[6:0], 1'b0};
                tx_cnt_reg <= tx_cnt_reg + 4'd1;
            end
        end
    end

    // Backdoor writes only happen in IDLE and SPI writes only in WRITE, so one write port suffices.
    assign mem_we = mem_we_spi || bd_ok;
    assign mem_wa = bd_ok ? bd_addr : addr_reg;
    assign mem_wd = bd_ok ? bd_wdata : rx_byte;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        mem_q <= mem[addr_reg];
    end
endmodule

// File: tb/tb_spi_sram_slave.sv
// Scenario bench for spi_sram_slave: SPI master tasks, backdoor access and a queue of expected bytes.
module tb_spi_sram_slave;
    logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00, bd_wdata = 8'h00;
    logic       miso, miso_oe, bd_err;
    logic [1:0] mode_o;
    logic [7:0] bd_rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    spi_sram_slave #(.MEM_BYTES(256), .ADDR_BYTES(2), .PAGE_BYTES(32)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode_o(mode_o),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata), .bd_err(bd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a; bd_wdata = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        @(negedge clk);
        d = bd_rdata;
    endtask

    // Master samples miso just before each rising edge.
    task automatic spi_bit(input logic b, output logic m, output logic oe);
        mosi = b;
        wait_clk(6);
        m  = miso;
        oe = miso_oe;
        sck = 1'b1;
        wait_clk(6);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                            output logic oe_all, output logic oe_any);
        logic m, oe;
        oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m, oe);
            rx[i]  = m;
            oe_all = oe_all & oe;
            oe_any = oe_any | oe;
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_cmd(input logic [7:0] op, input logic [15:0] a, output logic oe_any);
        logic [7:0] rx;
        logic all, any;
        oe_any = 1'b0;
        spi_byte(op, rx, all, any);      oe_any |= any;
        spi_byte(a[15:8], rx, all, any); oe_any |= any;
        spi_byte(a[7:0], rx, all, any);  oe_any |= any;
    endtask

    task automatic spi_wrmr(input logic [7:0] v);
        logic [7:0] rx;
        logic all, any;
        cs_start();
        spi_byte(8'h01, rx, all, any);
        spi_byte(v, rx, all, any);
        cs_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(1);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", miso_oe); end
        checks++; if (bd_rdata !== 8'h00) begin errors++; $display("FAIL reset_bd_rdata got %h want 00", bd_rdata); end
        checks++; if (bd_err !== 1'b0) begin errors++; $display("FAIL reset_bd_err got %b want 0", bd_err); end
        checks++; if (mode_o !== 2'b01) begin errors++; $display("FAIL reset_mode got %b want 01", mode_o); end
    endtask

    task automatic test_read();
        logic [7:0] rx, exp;
        logic all, any;
        logic [7:0] pre[5] = '{8'h11, 8'h21, 8'h21, 8'h80, 8'h63};
        bd_write(8'h00, pre[0]);
        checks++; if (bd_rdata !== 8'h11) begin errors++; $display("FAIL bd_write_first got %h want 11", bd_rdata); end
        for (int i = 1; i < 5; i++) bd_write(8'(i), pre[i]);
        for (int i = 0; i < 5; i++) exp_q.push_back(pre[i]);
        cs_start();
        spi_cmd(8'h03, 16'h0000, any);
        checks++; if (any !== 1'b0) begin errors++; $display("FAIL read_oe_cmd got %b want 0", any); end
        for (int i = 0; i < 5; i++) begin
            spi_byte(8'h00, rx, all, any);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, rx, exp); end
            checks++; if (all !== 1'b1) begin errors++; $display("FAIL read_oe_data%0d got %b want 1", i, all); end
        end
        cs_end();
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after got %b want 0", miso_oe); end
        $display("read 0x0000 x5 done");
    endtask

    task automatic test_write_wrap();
        logic [7:0] rx, d, exp;
        logic all, any;
        logic [7:0] a[3] = '{8'hFE, 8'hFF, 8'h00};
        cs_start();
        spi_cmd(8'h02, 16'h00FE, any);
        spi_byte(8'hAA, rx, all, any); exp_q.push_back(8'hAA);
        spi_byte(8'hBB, rx, all, any); exp_q.push_back(8'hBB);
        spi_byte(8'hCC, rx, all, any); exp_q.push_back(8'hCC);
        cs_end();
        for (int i = 0; i < 3; i++) begin
            bd_read(a[i], d);
            exp = exp_q.pop_front();
            checks++; if (d !== exp) begin errors++; $display("FAIL write_wrap mem[%h] got %h want %h", a[i], d, exp); end
        end
        $display("write 0x00FE AA BB CC done");
    endtask

    task automatic test_page();
        logic [7:0] rx, d, exp;
        logic all, any;
        logic [7:0] a[3] = '{8'h1F, 8'h00, 8'h20};
        spi_wrmr(8'h80);
        checks++; if (mode_o !== 2'b10) begin errors++; $display("FAIL wrmr_page got %b want 10", mode_o); end
        bd_write(8'h20, 8'h5A);
        cs_start();
        spi_cmd(8'h02, 16'h001F, any);
        spi_byte(8'h01, rx, all, any); exp_q.push_back(8'h01);
        spi_byte(8'h02, rx, all, any); exp_q.push_back(8'h02);
        exp_q.push_back(8'h5A);
        cs_end();
        for (int i = 0; i < 3; i++) begin
            bd_read(a[i], d);
            exp = exp_q.pop_front();
            checks++; if (d !== exp) begin errors++; $display("FAIL page_write mem[%h] got %h want %h", a[i], d, exp); end
        end
        $display("page write 0x001F 01 02 done");
    endtask

    task automatic test_byte_mode();
        logic [7:0] rx, exp;
        logic all, any;
        spi_wrmr(8'h00);
        checks++; if (mode_o !== 2'b00) begin errors++; $display("FAIL wrmr_byte got %b want 00", mode_o); end
        bd_write(8'h10, 8'h3C);
        bd_write(8'h11, 8'hC3);
        exp_q.push_back(8'h3C);
        cs_start();
        spi_cmd(8'h03, 16'h0010, any);
        spi_byte(8'h00, rx, all, any);
        exp = exp_q.pop_front();
        checks++; if (rx !== exp) begin errors++; $display("FAIL byte_mode_read got %h want %h", rx, exp); end
        checks++; if (all !== 1'b1) begin errors++; $display("FAIL byte_mode_oe1 got %b want 1", all); end
        spi_byte(8'h00, rx, all, any);
        checks++; if (any !== 1'b0) begin errors++; $display("FAIL byte_mode_oe2 got %b want 0", any); end
        cs_end();
        // RDMR in byte mode, then back to sequential and RDMR twice
        cs_start();
        spi_byte(8'h05, rx, all, any);
        exp_q.push_back(8'h00);
        spi_byte(8'h00, rx, all, any);
        exp = exp_q.pop_front();
        checks++; if (rx !== exp || all !== 1'b1) begin errors++; $display("FAIL rdmr_00 got %h oe %b want %h oe 1", rx, all, exp); end
        cs_end();
        spi_wrmr(8'h40);
        checks++; if (mode_o !== 2'b01) begin errors++; $display("FAIL wrmr_seq got %b want 01", mode_o); end
        cs_start();
        spi_byte(8'h05, rx, all, any);
        exp_q.push_back(8'h40); exp_q.push_back(8'h40);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx, all, any);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp || all !== 1'b1) begin errors++; $display("FAIL rdmr_40_%0d got %h oe %b want %h oe 1", i, rx, all, exp); end
        end
        cs_end();
        $display("byte mode read and rdmr done");
    endtask

    task automatic test_ignore_bd();
        logic [7:0] rx, d, exp;
        logic all, any, oe_acc;
        logic [7:0] a[2] = '{8'h05, 8'h01};
        bd_write(8'h05, 8'h77);
        oe_acc = 1'b0;
        cs_start();
        spi_byte(8'h9F, rx, all, any); oe_acc |= any;
        spi_byte(8'h02, rx, all, any); oe_acc |= any;
        spi_byte(8'h00, rx, all, any); oe_acc |= any;
        spi_byte(8'h05, rx, all, any); oe_acc |= any;
        bd_addr = 8'h05; bd_wdata = 8'hEE; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
        checks++; if (bd_err !== 1'b1) begin errors++; $display("FAIL bd_err_pulse got %b want 1", bd_err); end
        @(negedge clk);
        checks++; if (bd_err !== 1'b0) begin errors++; $display("FAIL bd_err_len got %b want 0", bd_err); end
        spi_byte(8'hEE, rx, all, any); oe_acc |= any;
        cs_end();
        checks++; if (oe_acc !== 1'b0) begin errors++; $display("FAIL ignore_oe got %b want 0", oe_acc); end
        exp_q.push_back(8'h77); exp_q.push_back(8'h21);
        for (int i = 0; i < 2; i++) begin
            bd_read(a[i], d);
            exp = exp_q.pop_front();
            checks++; if (d !== exp) begin errors++; $display("FAIL ignore_mem[%h] got %h want %h", a[i], d, exp); end
        end
        $display("opcode 9F and blocked backdoor write done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx, exp;
        logic all, any, m, oe, oe_acc;
        spi_wrmr(8'h80);
        cs_start();
        spi_cmd(8'h03, 16'h0000, any);
        exp_q.push_back(8'h02);
        spi_byte(8'h00, rx, all, any);
        exp = exp_q.pop_front();
        checks++; if (rx !== exp) begin errors++; $display("FAIL pre_reset_read got %h want %h", rx, exp); end
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m, oe);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin errors++; $display("FAIL mid_reset_out got miso %b oe %b want 0 0", miso, miso_oe); end
        checks++; if (mode_o !== 2'b01) begin errors++; $display("FAIL mid_reset_mode got %b want 01", mode_o); end
        oe_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin spi_bit(1'b0, m, oe); oe_acc |= oe; end
        spi_byte(8'h00, rx, all, any); oe_acc |= any;
        cs_end();
        checks++; if (oe_acc !== 1'b0) begin errors++; $display("FAIL post_reset_bus got oe %b want 0", oe_acc); end
        exp_q.push_back(8'h02); exp_q.push_back(8'h21); exp_q.push_back(8'h21);
        cs_start();
        spi_cmd(8'h03, 16'h0000, any);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx, all, any);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp || all !== 1'b1) begin errors++; $display("FAIL post_reset_read%0d got %h oe %b want %h oe 1", i, rx, all, exp); end
        end
        cs_end();
        $display("reset mid-read and recovery read done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read();
        test_write_wrap();
        test_page();
        test_byte_mode();
        test_ignore_bd();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
